// File: rtl/video_stream_mem_writer_pkg.sv
// Shared types and constants for the video stream frame-memory writer.
// Optional feature macro: VIDEO_WRITER_FRAME_CNT_EN (adds frame_count output).
package video_writer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SKIP    = 2'd2
    } state_t;

    typedef logic [15:0] pixel_t;

    localparam logic [3:0] PKT_VIDEO = 4'h0;
    localparam logic [3:0] PKT_CTRL  = 4'hF;

    localparam logic [3:0] BE_FULL = 4'hF;
    localparam logic [3:0] BE_LOW  = 4'b0011;

    localparam int unsigned DEF_FRAME_WORDS = 2048;

endpackage

// File: rtl/video_stream_mem_writer_if.sv
// Avalon-ST video handshake bundle between the decoder/clipper (master)
// and the frame-memory writer (slave).
interface video_stream_mem_writer_if;
    import video_writer_pkg::*;

    pixel_t stream_data;
    logic   stream_startofpacket;
    logic   stream_endofpacket;
    logic   stream_valid;
    logic   stream_ready;

    modport master (
        output stream_data,
        output stream_startofpacket,
        output stream_endofpacket,
        output stream_valid,
        input  stream_ready
    );

    modport slave (
        input  stream_data,
        input  stream_startofpacket,
        input  stream_endofpacket,
        input  stream_valid,
        output stream_ready
    );

endinterface

// File: rtl/video_stream_mem_writer_pack.sv
// Packs two RGB565 pixels into one 32-bit word and issues the registered
// write strobe; a last pixel landing on an even slot is written as a half word.
module pixel_pack_2to1
    import video_writer_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        pix_valid,
    input  logic        pix_last,
    input  pixel_t      pix_data,
    output logic        fire,
    output logic        wr,
    output logic [31:0] wdata,
    output logic [3:0]  be
);

    logic   odd;
    pixel_t low_q;

    // A word leaves this beat when it completes a pair or ends the packet.
    assign fire = pix_valid & (odd | pix_last);

    // Parity, held low half and registered memory word/strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            odd   <= 1'b0;
            low_q <= '0;
            wr    <= 1'b0;
            wdata <= '0;
            be    <= '0;
        end else begin
            wr <= 1'b0;
            if (flush) begin
                odd <= 1'b0;
            end else if (pix_valid) begin
                if (odd) begin
                    wr    <= 1'b1;
                    wdata <= {pix_data, low_q};
                    be    <= BE_FULL;
                    odd   <= 1'b0;
                end else if (pix_last) begin
                    wr    <= 1'b1;
                    wdata <= {16'h0000, pix_data};
                    be    <= BE_LOW;
                end else begin
                    low_q <= pix_data;
                    odd   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/video_stream_mem_writer.sv
// Avalon-ST video sink capturing one RGB565 frame into the on-chip frame
// memory, two pixels per 32-bit word.
// Optional feature macro: VIDEO_WRITER_FRAME_CNT_EN adds frame_count[15:0].
module video_stream_mem_writer
    import video_writer_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS
) (
    input  logic                       clk,
    input  logic                       reset_n,
    video_stream_mem_writer_if.slave   stream,
    input  logic                       enable,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [3:0]                 mem_byteenable,
    output logic                       mem_chipselect,
    output logic                       mem_write,
    output logic [31:0]                mem_writedata,
    output logic                       mem_clken,
    output logic                       frame_done,
    output logic                       overflow
`ifdef VIDEO_WRITER_FRAME_CNT_EN
   ,output logic [15:0]                frame_count
`endif
);

    // Pointer is one bit wider so the end-of-buffer address is representable.
    localparam logic [ADDR_W:0] BASE_PTR = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] END_PTR  = (ADDR_W+1)'(BASE_ADDR + FRAME_WORDS);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   ptr;
    logic              accept, is_sop, is_eop, full;
    logic              start_cap, pix_valid, ovf_hit, done_d, pix_fire;

    assign accept = stream.stream_valid & stream.stream_ready;
    assign is_sop = stream.stream_startofpacket;
    assign is_eop = stream.stream_endofpacket;
    assign full   = (ptr == END_PTR);

    assign mem_chipselect = mem_write;
    assign mem_clken      = 1'b1;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Packet decode: an SOP restarts decoding from any state, which also
    // abandons a truncated frame without a frame_done.
    always_comb begin
        state_d   = state_q;
        start_cap = 1'b0;
        pix_valid = 1'b0;
        ovf_hit   = 1'b0;
        done_d    = 1'b0;
        if (accept) begin
            if (is_sop) begin
                if ((stream.stream_data[3:0] == PKT_VIDEO) && enable) begin
                    state_d   = CAPTURE;
                    start_cap = 1'b1;
                end else begin
                    state_d = SKIP;
                end
                if (is_eop) state_d = IDLE;
            end else begin
                case (state_q)
                    CAPTURE: begin
                        if (full) begin
                            ovf_hit = 1'b1;
                        end else begin
                            pix_valid = 1'b1;
                            done_d    = is_eop;
                        end
                        if (is_eop) state_d = IDLE;
                    end
                    SKIP: begin
                        if (is_eop) state_d = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    pixel_pack_2to1 u_pack (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (accept & is_sop),
        .pix_valid (pix_valid),
        .pix_last  (is_eop),
        .pix_data  (stream.stream_data),
        .fire      (pix_fire),
        .wr        (mem_write),
        .wdata     (mem_writedata),
        .be        (mem_byteenable)
    );

    // Word pointer, registered address, overflow flag, ready and done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr                 <= BASE_PTR;
            mem_address         <= ADDR_W'(BASE_ADDR);
            overflow            <= 1'b0;
            frame_done          <= 1'b0;
            stream.stream_ready <= 1'b0;
        end else begin
            stream.stream_ready <= 1'b1;
            frame_done          <= done_d;
            if (start_cap) begin
                ptr      <= BASE_PTR;
                overflow <= 1'b0;
            end else begin
                if (pix_fire) begin
                    ptr         <= ptr + PTR_ONE;
                    mem_address <= ptr[ADDR_W-1:0];
                end
                if (ovf_hit) overflow <= 1'b1;
            end
        end
    end

`ifdef VIDEO_WRITER_FRAME_CNT_EN
    // Completed-frame counter, wrapping at 16 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    frame_count <= '0;
        else if (done_d) frame_count <= frame_count + 16'd1;
    end
`endif

endmodule
